// File: rtl/ladybird_config.sv
// Shared definitions for the ladybird core: RV32I instruction encoders, the
// boot image stored at word 0 of program memory, and the SRAM state type.
package ladybird_config;

  typedef enum logic {INIT, READY} sram_state_t;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [6:0] op);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
  endfunction

  function automatic logic [31:0] lui(input logic [4:0] rd, input logic [19:0] imm);
    return enc_u(imm, rd, OP_LUI);
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return enc_i(imm, rs1, 3'b000, rd, OP_IMM);
  endfunction

  function automatic logic [31:0] andi(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return enc_i(imm, rs1, 3'b111, rd, OP_IMM);
  endfunction

  function automatic logic [31:0] slli(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] sh);
    return enc_i({7'b0000000, sh}, rs1, 3'b001, rd, OP_IMM);
  endfunction

  function automatic logic [31:0] srli(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] sh);
    return enc_i({7'b0000000, sh}, rs1, 3'b101, rd, OP_IMM);
  endfunction

  function automatic logic [31:0] srai(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] sh);
    return enc_i({7'b0100000, sh}, rs1, 3'b101, rd, OP_IMM);
  endfunction

  function automatic logic [31:0] lb(input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [11:0] imm);
    return enc_i(imm, rs1, 3'b000, rd, OP_LOAD);
  endfunction

  function automatic logic [31:0] sb(input logic [4:0] rs2, input logic [4:0] rs1,
                                     input logic [11:0] imm);
    return enc_s(imm, rs2, rs1, 3'b000, OP_STORE);
  endfunction

  function automatic logic [31:0] jal(input logic [4:0] rd, input logic [20:0] imm);
    return enc_j(imm, rd, OP_JAL);
  endfunction

  function automatic logic [31:0] nop();
    return addi(5'd0, 5'd0, 12'd0);
  endfunction

  // Reads the byte at 0xffffffff, clears bit 0 and writes it back, forever.
  function automatic logic [31:0] boot_image(input int i);
    case (i)
      0:       return lui(5'd1, 20'hfffff);
      1:       return srai(5'd1, 5'd1, 5'd12);
      2:       return lb(5'd2, 5'd1, 12'd0);
      3:       return andi(5'd2, 5'd2, 12'hffe);
      4:       return slli(5'd2, 5'd2, 5'd1);
      5:       return srli(5'd2, 5'd2, 5'd1);
      6:       return sb(5'd2, 5'd1, 12'd0);
      7:       return jal(5'd0, 21'(-20));
      default: return nop();
    endcase
  endfunction

endpackage

// File: rtl/ladybird_bus.sv
// Core memory bus. data is shared: the secondary's read result wins while
// data_gnt is high, otherwise the primary's write data, otherwise high-Z.
interface ladybird_bus #(
  parameter int DATA_W = 32
);
  logic                  req;
  logic [31:0]           addr;
  logic [DATA_W/8-1:0]   wstrb;
  logic [DATA_W-1:0]     wdata;
  logic                  wdrive;
  logic [DATA_W-1:0]     rdata;
  logic                  gnt;
  logic                  data_gnt;
  wire  [DATA_W-1:0]     data;

  assign data = data_gnt ? rdata : (wdrive ? wdata : 'z);

  modport primary (output req, addr, wstrb, wdata, wdrive, input gnt, data_gnt, data);
  modport secondary (input req, addr, wstrb, data, output gnt, data_gnt, rdata);
endinterface

// File: rtl/ladybird_sram_rdpipe.sv
// Read-return shift pipeline: DEPTH stages of valid/data, valids cleared by rst.
module ladybird_sram_rdpipe #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);
  logic [DEPTH-1:0]             vld_q;
  logic [DEPTH-1:0][DATA_W-1:0] dat_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  // Data carries no reset; it is only observed alongside its valid bit.
  always_ff @(posedge clk) begin
    dat_q[0] <= in_data;
    for (int i = 1; i < DEPTH; i++) dat_q[i] <= dat_q[i-1];
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_data  = dat_q[DEPTH-1];
endmodule

// File: rtl/ladybird_sram.sv
// Word-addressed program/data SRAM for the ladybird core. Fills itself with the
// boot image (NOP elsewhere) after reset, then serves strobed writes and reads.
//   state | meaning
//   INIT  | one word per cycle written from cnt, bus stalled (gnt=0)
//   READY | bus requests accepted every cycle
module ladybird_sram
  import ladybird_config::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 10,
  parameter int RD_LATENCY = 1,
  parameter int BOOT_WORDS = 8
) (
  input  logic             clk,
  input  logic             rst,
  ladybird_bus.secondary   bus,
  output logic             init_done
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int NB    = DATA_W / 8;

  logic [DATA_W-1:0] ram [DEPTH];

  sram_state_t       state_q, state_d;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] idx;
  logic              gnt, wr_acc, rd_acc;
  logic [DATA_W-1:0] init_word;
  logic              pipe_valid;
  logic [DATA_W-1:0] pipe_data;

  assign idx    = bus.addr[ADDR_W+1:2];
  assign wr_acc = gnt & bus.req & (|bus.wstrb);
  assign rd_acc = gnt & bus.req & ~(|bus.wstrb);

  assign init_word = (int'(cnt_q) < BOOT_WORDS) ? DATA_W'(boot_image(int'(cnt_q)))
                                                : DATA_W'(nop());

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT) cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt       = 1'b0;
    init_done = 1'b0;
    case (state_q)
      INIT:    if (&cnt_q) state_d = READY;
      READY: begin
        gnt       = 1'b1;
        init_done = 1'b1;
      end
      default: state_d = INIT;
    endcase
  end

  // The array has no reset of its own; INIT rewrites every word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == INIT) begin
        ram[cnt_q] <= init_word;
      end else if (wr_acc) begin
        for (int b = 0; b < NB; b++)
          if (bus.wstrb[b]) ram[idx][b*8 +: 8] <= bus.data[b*8 +: 8];
      end
    end
  end

  ladybird_sram_rdpipe #(
    .DATA_W (DATA_W),
    .DEPTH  (RD_LATENCY)
  ) u_rdpipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_acc),
    .in_data   (ram[idx]),
    .out_valid (pipe_valid),
    .out_data  (pipe_data)
  );

  assign bus.gnt      = gnt;
  assign bus.data_gnt = pipe_valid;
  assign bus.rdata    = pipe_data;
endmodule

// File: doc/ladybird_sram.md
# ladybird_sram

Parametrised single-port word-addressed SRAM secondary for `ladybird_bus`. It is the next-generation program/data memory for the ladybird core. It adds:
- configurable data width, depth and read latency;
- a multi-cycle boot-image initialisation sequencer;
- a fully synchronous active-high reset.

It sits on the core's memory bus in place of the single-cycle RAM and holds the boot program at word 0.

## Interface
Parameters:
- `DATA_W`, 32, word width in bits; multiple of 8, 32 or 64.
- `ADDR_W`, 10, word-address width; depth = 2**`ADDR_W`.
- `RD_LATENCY`, 1, cycles from accepted read to `data_gnt`; range 1..4.
- `BOOT_WORDS`, 8, number of words taken from the package boot image; must be ≤ 2**`ADDR_W`.

Ports:
- `clk`  input  1  single clock; everything is rising-edge.
- `rst`  input  1  reset; synchronous, active-high.
- `bus`  modport `ladybird_bus.secondary`  —  uses `req`, `addr`, `wstrb` (`DATA_W`/8), `data` (`DATA_W`), `gnt`, `data_gnt`.
- `init_done`  output  1  high once the boot image is fully written.

## Operation
- Word index = `bus.addr[ADDR_W+1:2]`. Lower 2 bits are ignored. Upper bits are ignored, so addresses alias modulo depth.
- FSM states: `INIT`, `READY`.
- `rst` high forces `INIT` and clears the init counter to 0.
- **`INIT` state:**
  - One word is written per cycle: `ram[cnt] <= (cnt < BOOT_WORDS) ? boot_image(cnt) : NOP()`.
  - `cnt` increments each cycle.
  - When `cnt` = 2**`ADDR_W`-1 is written, the FSM goes to `READY` on the next edge.
  - `gnt`=0 throughout; `req` is ignored.
- **`READY` state:**
  - `gnt`=1 whenever not in reset; a request is accepted when `req`=1.
- **Write** (`req` and `wstrb`≠0):
  - Byte lane i of `ram[idx]` is updated only where `wstrb[i]`=1.
  - No `data_gnt` is produced; nothing enters the read pipeline.
- **Read** (`req` and `wstrb`=0):
  - `ram[idx]` is sampled at the accepting edge.
  - The sample is pushed into an `RD_LATENCY`-deep valid/data shift pipeline.
- **Bus drive:**
  - `bus.data` = pipeline head data when the head is valid, otherwise `'z`.
  - `data_gnt` = head valid.
- **Read after write:** a read accepted the cycle after a write to the same word returns the new data, because the array is updated at the write edge.
- **Back-to-back reads:** one per cycle; `data_gnt` stays high continuously for consecutive reads.
- **Reset mid-operation:** all pipeline valids clear and `data_gnt`=0 from the first edge with `rst`=1; in-flight reads are dropped. The array is re-initialised by `INIT`.

## Timing
Reset values (registered outputs, after the first `rst` edge):
- `gnt`=0, `data_gnt`=0, `bus.data`='z, `init_done`=0.

Init duration:
- `rst` deasserts at edge E0; `init_done` and `gnt` rise after edge E0 + 2**`ADDR_W`.
- With the default `ADDR_W`=10, that is 1024 cycles.

Read latency:
- A read accepted at edge T gives `data_gnt`=1 and valid `bus.data` in the cycle following edge T+`RD_LATENCY`-1.
- For `RD_LATENCY`=1, data is visible the cycle after `req`, matching the previous RAM.

Write latency:
- A write accepted at edge T is visible to any read accepted at edge T+1 or later.

`rst` asserted during `INIT`:
- The counter restarts at 0.

## Structure
- `ladybird_config` package holds:
  - `boot_image(int)`, returning the instruction word. Image: LUI x1,0xfffff; SRAI x1,x1,12; LB x2,0(x1); ANDI x2,x2,0xffe; SLLI x2,x2,1; SRLI x2,x2,1; SB x2,0(x1); J -20.
  - The existing instruction encoders.
  - `typedef enum logic {INIT, READY} sram_state_t`.
- Sub-module `ladybird_sram_rdpipe` (parameters `DATA_W`, `DEPTH`, inputs `rst`/in_valid/in_data, outputs out_valid/out_data) implements the read shift pipeline.
- The array, strobe writes and FSM stay in the top.

## Test plan
- **Init:** `rst` high 2 cycles, then low → `gnt`=0 for exactly 1024 cycles, then 1. Reads of words 0..7 return the boot image, e.g. word 0 = LUI(1,0xfffff). Word 8 returns NOP (0x00000013).
- **Strobed write:**
  - Write 0xAABBCCDD to addr 0x40 with `wstrb`=0xF, then write 0x11223344 with `wstrb`=0x5.
  - Read 0x40 → 0xAA22CC44.
  - Write cycles show `data_gnt`=0.
- **Latency sweep:** for `RD_LATENCY` ∈ {1,2,4}, read addr 0x0 → `data_gnt` rises exactly `RD_LATENCY` cycles after the accept edge, and `bus.data` is 'z in every other cycle.
- **Back-to-back:** 4 consecutive reads of 0x0, 0x4, 0x8, 0xC (`RD_LATENCY`=2) → 4 consecutive `data_gnt` cycles, with data in order.
- **Aliasing and read after write:**
  - Write 0xDEADBEEF to addr 0x1000 (aliases word 0), then read addr 0x0 on the next cycle → 0xDEADBEEF.
- **Mid-read reset** (`RD_LATENCY`=3):
  - Issue a read, then assert `rst` on the next edge → `data_gnt` never asserts for that read.
  - `gnt`=0 until init completes again.
  - Word 0 returns to the boot value.
